// File: rtl/accel_controller_pkg.sv
// Shared types for the accelerator sequencing controller: state encoding,
// registered control-word layout and the state-to-enable decode.
package accel_controller_pkg;

    localparam int unsigned DEF_ARRAYWIDTH = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        PUSH_W = 3'd2,
        LOAD_A = 3'd3,
        STREAM = 3'd4,
        DRAIN  = 3'd5,
        DONE   = 3'd6
    } state_e;

    typedef struct packed {
        logic busy;
        logic done;
        logic out_valid;
        logic input_buffer_load_en;
        logic input_buffer_out_en;
        logic input_buffer_delay_clear;
        logic weight_buffer_load_en;
        logic weight_buffer_out_en;
        logic write_weight_en;
        logic output_buffer_load_en;
        logic output_buffer_out_en;
        logic output_buffer_load_clear;
        logic output_buffer_acc_enable;
        logic output_buffer_acc_clear;
        logic relu_en;
    } ctrl_t;

    function automatic int unsigned default_stream_cycles(int unsigned n);
        return 3 * n - 1;
    endfunction

    // Enables for the cycle spent in state st; first marks the entry cycle.
    function automatic ctrl_t decode_ctrl(state_e st, logic first, logic tile_zero, logic relu);
        ctrl_t c;
        c = '0;
        c.busy = (st != IDLE);
        case (st)
            LOAD_W: begin
                c.weight_buffer_load_en    = 1'b1;
                c.output_buffer_acc_clear  = first & tile_zero;
            end
            PUSH_W: begin
                c.weight_buffer_out_en     = 1'b1;
                c.write_weight_en          = 1'b1;
            end
            LOAD_A: begin
                c.input_buffer_load_en     = 1'b1;
                c.input_buffer_delay_clear = first;
            end
            STREAM: begin
                c.input_buffer_out_en      = 1'b1;
                c.output_buffer_load_en    = 1'b1;
                c.output_buffer_acc_enable = ~tile_zero;
            end
            DRAIN: begin
                c.output_buffer_out_en     = 1'b1;
                c.out_valid                = 1'b1;
                c.relu_en                  = relu;
            end
            DONE: begin
                c.done                     = 1'b1;
                c.output_buffer_load_clear = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/accel_controller_phase_counter.sv
// Per-phase up-counter: restarts at 0 when loaded and flags the last cycle.
module phase_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] last,
    output logic             tc_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc_c = (cnt == last);

endmodule

// File: rtl/accel_controller.sv
// Sequencing FSM for one tiled accelerator job. Optional relu on the drained
// result is built only when CTRL_RELU_EN is defined.
module accel_controller
    import accel_controller_pkg::*;
#(
    parameter int unsigned ARRAYWIDTH    = DEF_ARRAYWIDTH,
    parameter int unsigned TILE_W        = 8,
    parameter int unsigned STREAM_CYCLES = default_stream_cycles(ARRAYWIDTH),
    parameter int unsigned CNT_W         = $clog2(STREAM_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              relu_cfg,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    output logic              input_buffer_load_en,
    output logic              input_buffer_out_en,
    output logic              input_buffer_delay_clear,
    output logic              weight_buffer_load_en,
    output logic              weight_buffer_out_en,
    output logic              write_weight_en,
    output logic              output_buffer_load_en,
    output logic              output_buffer_out_en,
    output logic              output_buffer_load_clear,
    output logic              output_buffer_acc_enable,
    output logic              output_buffer_acc_clear,
    output logic              relu_en,
    output logic              softmax_en
);

    state_e            state_q, state_next;
    logic [TILE_W-1:0] tile_idx, tile_next;
    logic [TILE_W-1:0] num_q, num_next;
    logic [TILE_W:0]   tile_inc;
    logic [CNT_W-1:0]  phase_last;
    logic              phase_tc, cnt_load, relu_dec;
    ctrl_t             ctrl_q, ctrl_d;

`ifdef CTRL_RELU_EN
    logic relu_q, relu_next;
`else
    logic unused_relu_cfg;
    assign unused_relu_cfg = relu_cfg;
`endif

    // Terminal count of the current phase, from registered state only.
    always_comb begin
        phase_last = CNT_W'(ARRAYWIDTH - 1);
        case (state_q)
            IDLE, DONE: phase_last = '0;
            STREAM:     phase_last = CNT_W'(STREAM_CYCLES - 1);
            default:    phase_last = CNT_W'(ARRAYWIDTH - 1);
        endcase
    end

    phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .last (phase_last),
        .tc_c (phase_tc)
    );

    // Next state plus decode of the next cycle's enables, so outputs leave a flop.
    always_comb begin
        state_next = state_q;
        tile_next  = tile_idx;
        num_next   = num_q;
        tile_inc   = {1'b0, tile_idx} + (TILE_W + 1)'(1);
`ifdef CTRL_RELU_EN
        relu_next  = relu_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_next = LOAD_W;
                    tile_next  = '0;
                    num_next   = (num_tiles == '0) ? TILE_W'(1) : num_tiles;
`ifdef CTRL_RELU_EN
                    relu_next  = relu_cfg;
`endif
                end
            end
            LOAD_W: if (phase_tc) state_next = PUSH_W;
            PUSH_W: if (phase_tc) state_next = LOAD_A;
            LOAD_A: if (phase_tc) state_next = STREAM;
            STREAM: begin
                if (phase_tc) begin
                    if (tile_inc < {1'b0, num_q}) begin
                        tile_next  = tile_inc[TILE_W-1:0];
                        state_next = LOAD_W;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN:   if (phase_tc) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        cnt_load = (state_next != state_q) || (state_q == IDLE);
`ifdef CTRL_RELU_EN
        relu_dec = relu_next;
`else
        relu_dec = 1'b0;
`endif
        ctrl_d = decode_ctrl(state_next, state_next != state_q, tile_next == '0, relu_dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tile_idx <= '0;
            num_q    <= '0;
            ctrl_q   <= '0;
`ifdef CTRL_RELU_EN
            relu_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_next;
            tile_idx <= tile_next;
            num_q    <= num_next;
            ctrl_q   <= ctrl_d;
`ifdef CTRL_RELU_EN
            relu_q   <= relu_next;
`endif
        end
    end

    assign busy                     = ctrl_q.busy;
    assign done                     = ctrl_q.done;
    assign out_valid                = ctrl_q.out_valid;
    assign input_buffer_load_en     = ctrl_q.input_buffer_load_en;
    assign input_buffer_out_en      = ctrl_q.input_buffer_out_en;
    assign input_buffer_delay_clear = ctrl_q.input_buffer_delay_clear;
    assign weight_buffer_load_en    = ctrl_q.weight_buffer_load_en;
    assign weight_buffer_out_en     = ctrl_q.weight_buffer_out_en;
    assign write_weight_en          = ctrl_q.write_weight_en;
    assign output_buffer_load_en    = ctrl_q.output_buffer_load_en;
    assign output_buffer_out_en     = ctrl_q.output_buffer_out_en;
    assign output_buffer_load_clear = ctrl_q.output_buffer_load_clear;
    assign output_buffer_acc_enable = ctrl_q.output_buffer_acc_enable;
    assign output_buffer_acc_clear  = ctrl_q.output_buffer_acc_clear;
    assign relu_en                  = ctrl_q.relu_en;
    assign softmax_en               = 1'b0;

endmodule

// File: tb/tb_accel_controller.sv
// Scoreboard bench for accel_controller (N=4, STREAM_CYCLES=11): stimulus queues
// expected job summaries / idle snapshots, a monitor accumulates and compares.
module tb_accel_controller;

    localparam int N  = 4;
    localparam int SC = 11;
    localparam int P  = 3 * N + SC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       relu_cfg = 1'b0;
    logic [7:0] num_tiles = 8'd0;
    logic busy, done, out_valid;
    logic ib_load, ib_out, ib_dclr, wb_load, wb_out, w_wr;
    logic ob_load, ob_out, ob_lclr, ob_acc_en, ob_acc_clr, relu_en, softmax_en;

    accel_controller #(.ARRAYWIDTH(N), .TILE_W(8), .STREAM_CYCLES(SC)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .num_tiles                (num_tiles),
        .relu_cfg                 (relu_cfg),
        .busy                     (busy),
        .done                     (done),
        .out_valid                (out_valid),
        .input_buffer_load_en     (ib_load),
        .input_buffer_out_en      (ib_out),
        .input_buffer_delay_clear (ib_dclr),
        .weight_buffer_load_en    (wb_load),
        .weight_buffer_out_en     (wb_out),
        .write_weight_en          (w_wr),
        .output_buffer_load_en    (ob_load),
        .output_buffer_out_en     (ob_out),
        .output_buffer_load_clear (ob_lclr),
        .output_buffer_acc_enable (ob_acc_en),
        .output_buffer_acc_clear  (ob_acc_clr),
        .relu_en                  (relu_en),
        .softmax_en               (softmax_en)
    );

    typedef struct {
        bit is_zero;
        int cyc;
        int s;
        int tiles;
        bit relu;
        int done_rel;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int busy_n, wload_n, pushw_n, wwr_n, lda_n, dclr_n, dclr_first, aclr_n, aclr_first;
    int str_n, obl_n, acc_n, acc_first, acc_last, val_n, val_first, obo_n;
    int relu_n, relu_first, olc_n, ovl_n, gap_n, smx_n;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_acc();
        busy_n = 0; wload_n = 0; pushw_n = 0; wwr_n = 0; lda_n = 0;
        dclr_n = 0; dclr_first = -1; aclr_n = 0; aclr_first = -1;
        str_n = 0; obl_n = 0; acc_n = 0; acc_first = -1; acc_last = -1;
        val_n = 0; val_first = -1; obo_n = 0; relu_n = 0; relu_first = -1;
        olc_n = 0; ovl_n = 0; gap_n = 0; smx_n = 0;
    endtask

    // Monitor: accumulate per-job enable activity and compare on done / idle checkpoints.
    initial begin
        exp_t e;
        int   t, grp;
        bit   relu_on;
        clear_acc();
        forever begin
            @(negedge clk);
            if (!busy) begin
                clear_acc();
            end else begin
                busy_n++;
                wload_n += int'(wb_load); pushw_n += int'(wb_out); wwr_n += int'(w_wr);
                lda_n += int'(ib_load); str_n += int'(ib_out); obl_n += int'(ob_load);
                obo_n += int'(ob_out); olc_n += int'(ob_lclr); smx_n += int'(softmax_en);
                if (ib_dclr) begin dclr_n++; if (dclr_first < 0) dclr_first = cyc; end
                if (ob_acc_clr) begin aclr_n++; if (aclr_first < 0) aclr_first = cyc; end
                if (ob_acc_en) begin acc_n++; if (acc_first < 0) acc_first = cyc; acc_last = cyc; end
                if (out_valid) begin val_n++; if (val_first < 0) val_first = cyc; end
                if (relu_en) begin relu_n++; if (relu_first < 0) relu_first = cyc; end
                grp = int'(wb_load | ob_acc_clr) + int'(wb_out | w_wr) + int'(ib_load | ib_dclr)
                    + int'(ib_out | ob_load | ob_acc_en) + int'(ob_out | out_valid | relu_en)
                    + int'(done | ob_lclr);
                if (grp > 1) ovl_n++;
                if (grp == 0) gap_n++;
            end
            if (sb.size() > 0 && sb[0].is_zero && cyc >= sb[0].cyc) begin
                e = sb.pop_front();
                chk("idle_at_cycle", cyc, e.cyc);
                chk("idle_outputs", int'({busy, done, out_valid, ib_load, ib_out, ib_dclr, wb_load,
                    wb_out, w_wr, ob_load, ob_out, ob_lclr, ob_acc_en, ob_acc_clr, relu_en,
                    softmax_en}), 0);
            end
            if (done) begin
                if (sb.size() == 0 || sb[0].is_zero) begin
                    chk("unexpected_done", cyc, -1);
                end else begin
                    e = sb.pop_front();
                    t = (e.tiles == 0) ? 1 : e.tiles;
`ifdef CTRL_RELU_EN
                    relu_on = e.relu;
`else
                    relu_on = 1'b0;
`endif
                    chk("done_cycle", cyc, e.s + e.done_rel);
                    chk("busy_cycles", busy_n, P * t + N + 1);
                    chk("wload_cycles", wload_n, N * t);
                    chk("pushw_cycles", pushw_n, N * t);
                    chk("write_weight_cycles", wwr_n, N * t);
                    chk("loada_cycles", lda_n, N * t);
                    chk("acc_clear_cycles", aclr_n, 1);
                    chk("acc_clear_at", aclr_first, e.s + 1);
                    chk("delay_clear_cycles", dclr_n, t);
                    chk("delay_clear_first", dclr_first, e.s + 1 + 2 * N);
                    chk("stream_cycles", str_n, SC * t);
                    chk("ob_load_cycles", obl_n, SC * t);
                    chk("acc_enable_cycles", acc_n, SC * (t - 1));
                    chk("acc_enable_first", acc_first, (t > 1) ? e.s + 1 + P + 3 * N : -1);
                    chk("acc_enable_last", acc_last, (t > 1) ? e.s + P * t : -1);
                    chk("out_valid_cycles", val_n, N);
                    chk("out_valid_first", val_first, e.s + 1 + P * t);
                    chk("ob_out_cycles", obo_n, N);
                    chk("relu_cycles", relu_n, relu_on ? N : 0);
                    chk("relu_first", relu_first, relu_on ? e.s + 1 + P * t : -1);
                    chk("load_clear_cycles", olc_n, 1);
                    chk("phase_overlap", ovl_n, 0);
                    chk("phase_gap", gap_n, 0);
                    chk("softmax_cycles", smx_n, 0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input int s, input int tiles, input bit relu, input int done_rel);
        exp_t e;
        e = '{is_zero: 1'b0, cyc: 0, s: s, tiles: tiles, relu: relu, done_rel: done_rel};
        sb.push_back(e);
    endtask

    task automatic push_zero(input int c);
        exp_t e;
        e = '{is_zero: 1'b1, cyc: c, s: 0, tiles: 0, relu: 1'b0, done_rel: 0};
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && sb.size() > 0; i++) step();
        chk("scoreboard_empty", sb.size(), 0);
        step();
        step();
    endtask

    int v_tiles [4] = '{1, 2, 0, 3};
    bit v_relu  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int v_done  [4] = '{28, 51, 28, 74};

    initial begin
        int s;
        step();
        step();
        rst = 1'b0;
        push_zero(cyc);
        push_zero(cyc + 1);
        wait_drain(10);

        // Single, double, zero and triple tile jobs; inputs scrambled after start.
        for (int k = 0; k < 4; k++) begin
            s = cyc;
            push_job(s, v_tiles[k], v_relu[k], v_done[k]);
            num_tiles = 8'(v_tiles[k]);
            relu_cfg  = v_relu[k];
            start     = 1'b1;
            step();
            start     = 1'b0;
            num_tiles = 8'hFF;
            relu_cfg  = ~v_relu[k];
            wait_drain(120);
        end

        // Start while busy and during DONE; held start re-launches in IDLE.
        s = cyc;
        push_job(s, 1, 1'b0, 28);
        push_zero(s + 29);
        push_job(s + 29, 1, 1'b0, 28);
        num_tiles = 8'd1; relu_cfg = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1; relu_cfg = 1'b1; num_tiles = 8'd3;
        step();
        start = 1'b0; relu_cfg = 1'b0; num_tiles = 8'd1;
        repeat (22) step();
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        wait_drain(120);

        // Reset in STREAM aborts the job; next start completes normally.
        s = cyc;
        push_zero(s + 16);
        push_job(s + 17, 1, 1'b1, 28);
        num_tiles = 8'd2; relu_cfg = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (14) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        num_tiles = 8'd1; relu_cfg = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        wait_drain(120);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
